// File: rtl/vout_fpdlink.sv
// Y8 pixel-pair source to 42-bit FPD-Link parallel word with line/frame timing.
// Optional VOUT_FPDLINK_TESTPAT_EN adds a testpat input that replaces pixels with an hcnt ramp.
module vout_fpdlink #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 1200,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
`ifdef VOUT_FPDLINK_TESTPAT_EN
  input  logic        testpat,
`endif
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  output logic        frame_start,
  output logic        underflow,
  output logic [41:0] dout
);

  localparam int unsigned CW           = 12;
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic            frame_start_d;
  logic            h_last, v_last;
  logic            run, active, hs, vs, de, tp;
  logic [7:0]      y_even, y_odd;
  logic [5:0]      c_even, c_odd;
  logic [41:0]     word;

`ifdef VOUT_FPDLINK_TESTPAT_EN
  assign tp = testpat;
`else
  assign tp = 1'b0;
`endif

  // Next state and counter advance; counters only move while running
  always_comb begin
    state_d = state_q;
    hcnt_d  = '0;
    vcnt_d  = '0;
    h_last  = (hcnt_q == CW'(H_TOTAL - 1));
    v_last  = (vcnt_q == CW'(V_TOTAL - 1));
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          if (v_last) begin
            if (!en) state_d = IDLE;
          end else begin
            vcnt_d = vcnt_q + CW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
          vcnt_d = vcnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_start_d = (state_d == RUN) && (hcnt_d == '0) && (vcnt_d == '0);
  end

  assign run       = (state_q == RUN);
  assign active    = (hcnt_q < CW'(H_ACTIVE)) && (vcnt_q < CW'(V_ACTIVE));
  assign hs        = run && (hcnt_q >= CW'(H_SYNC_START)) && (hcnt_q < CW'(H_SYNC_END));
  assign vs        = run && (vcnt_q >= CW'(V_SYNC_START)) && (vcnt_q < CW'(V_SYNC_END));
  assign de        = run && active;
  assign pix_ready = de && !tp;

  // Pixel source selection: ramp, black on starvation, or the incoming pair
  always_comb begin
    y_even = 8'h00;
    y_odd  = 8'h00;
    if (de) begin
      if (tp) begin
        y_even = hcnt_q[7:0];
        y_odd  = hcnt_q[7:0];
      end else if (pix_valid) begin
        y_even = pix_data[15:8];
        y_odd  = pix_data[7:0];
      end
    end
    c_even = y_even[7:2];
    c_odd  = y_odd[7:2];
  end

  // R=G=B grey expanded into the 6-lane bit map
  always_comb begin
    word        = '0;
    word[40:35] = c_odd;
    word[32:28] = c_odd[5:1];
    word[41]    = c_odd[0];
    word[24:21] = c_odd[5:2];
    word[34:33] = c_odd[1:0];
    word[19:14] = c_even;
    word[11:7]  = c_even[5:1];
    word[20]    = c_even[0];
    word[3:0]   = c_even[5:2];
    word[13:12] = c_even[1:0];
    word[25]    = hs;
    word[26]    = vs;
    word[27]    = de;
    word[4]     = hs;
    word[5]     = vs;
    word[6]     = de;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      dout        <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_start <= frame_start_d;
      underflow   <= underflow | (pix_ready & ~pix_valid);
      dout        <= word;
    end
  end

endmodule

// File: tb/tb_vout_fpdlink.sv
// Scoreboard bench for vout_fpdlink using a reduced 8x6 timing.
module tb_vout_fpdlink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        testpat = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_ready, frame_start, underflow;
  logic [41:0] dout;

  int total = 0;
  int bad = 0;

  // reference model state
  logic        m_run = 1'b0;
  int          m_h = 0, m_v = 0;
  logic        m_uf = 1'b0;
  logic [41:0] exp_q[$];
  logic [41:0] pix_mask;

  vout_fpdlink #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef VOUT_FPDLINK_TESTPAT_EN
    .testpat(testpat),
`endif
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .frame_start(frame_start), .underflow(underflow), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] mk(input logic de, input logic hs, input logic vs,
                                     input logic [7:0] ye, input logic [7:0] yo);
    logic [41:0] w;
    logic [5:0] o, e;
    o = yo[7:2];
    e = ye[7:2];
    w = '0;
    w[41] = o[0]; w[40:35] = o; w[34:33] = o[1:0]; w[32:28] = o[5:1];
    w[27] = de; w[26] = vs; w[25] = hs; w[24:21] = o[5:2];
    w[20] = e[0]; w[19:14] = e; w[13:12] = e[1:0]; w[11:7] = e[5:1];
    w[6] = de; w[5] = vs; w[4] = hs; w[3:0] = e[5:2];
    return w;
  endfunction

  // One clock: drive inputs, check pix_ready, push expectation, check after edge
  task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
    logic ready, hs, vs, efs;
    logic [7:0] ye, yo;
    logic [41:0] exp_w, got_w;
    rst = r; en = e; pix_valid = v; pix_data = d;
    #1;
    ready = m_run && m_h < 4 && m_v < 3 && !testpat;
    total++;
    if (pix_ready !== ready) begin
      bad++;
      $display("FAIL pix_ready h=%0d v=%0d got=%b want=%b", m_h, m_v, pix_ready, ready);
    end
    hs = m_run && (m_h == 5 || m_h == 6);
    vs = m_run && (m_v == 4);
    ye = 8'h00; yo = 8'h00;
    if (m_run && m_h < 4 && m_v < 3) begin
      if (testpat) begin ye = 8'(m_h); yo = 8'(m_h); end
      else if (v) begin ye = d[15:8]; yo = d[7:0]; end
    end
    exp_w = (r || !m_run) ? 42'h0 : mk(m_run && m_h < 4 && m_v < 3, hs, vs, ye, yo);
    exp_q.push_back(exp_w);
    m_uf = r ? 1'b0 : (m_uf | (ready & ~v));
    if (r) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      m_run = e; m_h = 0; m_v = 0;
    end else if (m_h == 7) begin
      m_h = 0;
      if (m_v == 5) begin m_v = 0; if (!e) m_run = 1'b0; end
      else m_v++;
    end else m_h++;
    efs = m_run && m_h == 0 && m_v == 0;
    @(posedge clk);
    #1;
    got_w = exp_q.pop_front();
    total++;
    if (dout !== got_w) begin
      bad++;
      $display("FAIL dout got=%h want=%h", dout, got_w);
    end
    total++;
    if (frame_start !== efs) begin
      bad++;
      $display("FAIL frame_start got=%b want=%b", frame_start, efs);
    end
    total++;
    if (underflow !== m_uf) begin
      bad++;
      $display("FAIL underflow got=%b want=%b", underflow, m_uf);
    end
  endtask

  task automatic go_to(input int h, input int v);
    int n = 0;
    while (!(m_run && m_h == h && m_v == v) && n < 200) begin
      step(1'b0, 1'b1, 1'b1, 16'(($urandom)));
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL go_to timeout h=%0d v=%0d", h, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pix_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (dout !== 42'h0 || frame_start !== 1'b0 || underflow !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state dout=%h fs=%b uf=%b rdy=%b want all 0", dout, frame_start, underflow, pix_ready);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_frame();
    int fs_at[$];
    int vs_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'($urandom));
      if (frame_start) fs_at.push_back(i);
      if (dout[26]) vs_cnt++;
    end
    total++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != 48) begin
      bad++;
      $display("FAIL frame_period pulses=%0d first=%0d second=%0d want 2,0,48",
               fs_at.size(), fs_at.size() > 0 ? fs_at[0] : -1, fs_at.size() > 1 ? fs_at[1] : -1);
    end
    total++;
    if (vs_cnt != 16) begin
      bad++;
      $display("FAIL vsync_len got=%0d want=16", vs_cnt);
    end
  endtask

  task automatic test_pixel();
    go_to(0, 0);
    step(1'b0, 1'b1, 1'b1, 16'hFC80);
    total++;
    if (dout[40:35] !== 6'h20 || dout[41] !== 1'b0 || dout[19:14] !== 6'h3F ||
        dout[20] !== 1'b1 || dout[27] !== 1'b1 || dout[6] !== 1'b1) begin
      bad++;
      $display("FAIL pixel_map got=%h want odd=20 g0=0 even=3f g0=1 de=1", dout);
    end
  endtask

  task automatic test_underflow();
    go_to(1, 0);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    total++;
    if ((dout & pix_mask) !== 42'h0 || dout[27] !== 1'b1 || underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_black dout=%h uf=%b want pixels 0 de=1 uf=1", dout, underflow);
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b1, 16'($urandom));
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky got=%b want=1", underflow);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    int fs_cnt = 0;
    go_to(2, 1);
    while (m_run && n < 100) begin
      step(1'b0, 1'b0, 1'b1, 16'($urandom));
      n++;
    end
    total++;
    if (n != 38) begin
      bad++;
      $display("FAIL stop_len got=%0d want=38", n);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'($urandom));
      if (frame_start) fs_cnt++;
    end
    total++;
    if (fs_cnt != 0 || dout !== 42'h0) begin
      bad++;
      $display("FAIL idle_after_stop fs=%0d dout=%h want 0", fs_cnt, dout);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0, 16'h0);
    go_to(3, 2);
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    total++;
    if (dout !== 42'h0 || underflow !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid dout=%h uf=%b rdy=%b want 0", dout, underflow, pix_ready);
    end
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL restart_fs got=%b want=1", frame_start);
    end
  endtask

`ifdef VOUT_FPDLINK_TESTPAT_EN
  task automatic test_testpat();
    testpat = 1'b1;
    go_to(3, 0);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    total++;
    if (dout[40:35] !== 6'h00 || dout[41] !== 1'b0 || dout[27] !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL testpat dout=%h uf=%b want R=0 de=1 uf=0", dout, underflow);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    testpat = 1'b0;
  endtask
`endif

  initial begin
    pix_mask = '1;
    pix_mask[27:25] = 3'b000;
    pix_mask[6:4] = 3'b000;
    test_reset();
    test_frame();
    test_pixel();
`ifdef VOUT_FPDLINK_TESTPAT_EN
    test_testpat();
`endif
    test_underflow();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
